// File: rtl/cutie_wbuf_pkg.sv
// Shared types and width helpers for the multi-bank weight buffer.
// Optional CUTIE_WBUF_ZEROTAP_EN adds per-tap all-zero flags.
package cutie_wbuf_pkg;

  localparam int N_I_DEF     = 512;
  localparam int K_DEF       = 3;
  localparam int N_BANKS_DEF = 2;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ZERO = 2'b00;

  typedef trit_t [0:N_I_DEF-1] tap_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weightbuffer_bank.sv
// One kernel slot: K*K tap registers, tap-indexed write, sync clear.
// With CUTIE_WBUF_ZEROTAP_EN each tap also keeps an all-zero flag.
module weightbuffer_bank
  import cutie_wbuf_pkg::*;
#(
  parameter int N_I = N_I_DEF,
  parameter int K   = K_DEF
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [idx_w(K*K)-1:0]        tap,
  input  logic [N_I*2-1:0]             wr_data,
  output logic [K*K*N_I*2-1:0]         data
`ifdef CUTIE_WBUF_ZEROTAP_EN
  ,
  output logic [K*K-1:0]               zero
`endif
);

  localparam int KK  = K * K;
  localparam int TW  = N_I * 2;
  localparam int TCW = idx_w(KK);

  logic [KK-1:0][TW-1:0] taps;
  logic [TCW-1:0]        slot;

  // Tap 0 sits in the most significant slice.
  assign slot = TCW'(KK - 1) - tap;

  always_ff @(posedge clk) begin
    if (clr) begin
      taps <= '0;
    end else if (wr_en) begin
      taps[slot] <= wr_data;
    end
  end

  assign data = taps;

`ifdef CUTIE_WBUF_ZEROTAP_EN
  logic [KK-1:0] flags;

  always_ff @(posedge clk) begin
    if (clr) begin
      flags <= '0;
    end else if (wr_en) begin
      flags[slot] <= (wr_data == {N_I{TRIT_ZERO}});
    end
  end

  assign zero = flags;
`endif

endmodule

// File: rtl/weightbuffer_multibank.sv
// Ring of N_BANKS kernel slots between the weight-load stream and the OCU.
// Optional CUTIE_WBUF_ZEROTAP_EN exposes zero_tap_o for the read bank.
module weightbuffer_multibank
  import cutie_wbuf_pkg::*;
#(
  parameter int N_I     = N_I_DEF,
  parameter int K       = K_DEF,
  parameter int N_BANKS = N_BANKS_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [N_I*2-1:0]               wr_data_i,
  output logic                           rd_valid_o,
  input  logic                           rd_release_i,
  output logic [K*K*N_I*2-1:0]           rd_data_o,
  output logic [idx_w(N_BANKS)-1:0]      rd_bank_o,
  output logic [idx_w(N_BANKS):0]        fill_o
`ifdef CUTIE_WBUF_ZEROTAP_EN
  ,
  output logic [K*K-1:0]                 zero_tap_o
`endif
);

  localparam int KK  = K * K;
  localparam int TW  = N_I * 2;
  localparam int DW  = KK * TW;
  localparam int BW  = idx_w(N_BANKS);
  localparam int FW  = BW + 1;
  localparam int TCW = idx_w(KK);

  logic [BW-1:0]  wr_ptr;
  logic [BW-1:0]  rd_ptr;
  logic [TCW-1:0] tap_cnt;
  logic [FW-1:0]  fill;

  logic clr;
  logic full;
  logic wr_fire;
  logic done;
  logic rel;

  logic [N_BANKS-1:0][DW-1:0] bank_data;

  assign clr     = rst_i | flush_i;
  assign full    = (fill == FW'(N_BANKS));
  assign wr_fire = wr_valid_i & wr_ready_o;
  assign done    = wr_fire & (tap_cnt == TCW'(KK - 1));
  assign rel     = rd_release_i & rd_valid_o;

  // Ready depends on registered state and the clear inputs only.
  assign wr_ready_o = ~full & ~rst_i & ~flush_i;
  assign rd_valid_o = (fill != '0);
  assign rd_bank_o  = rd_ptr;
  assign fill_o     = fill;
  assign rd_data_o  = bank_data[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tap_cnt <= '0;
      fill    <= '0;
    end else begin
      if (wr_fire) begin
        tap_cnt <= done ? '0 : tap_cnt + 1'b1;
      end
      if (done) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rel) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({done, rel})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

`ifdef CUTIE_WBUF_ZEROTAP_EN
  logic [N_BANKS-1:0][KK-1:0] bank_zero;

  assign zero_tap_o = bank_zero[rd_ptr];
`endif

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    weightbuffer_bank #(
      .N_I (N_I),
      .K   (K)
    ) u_bank (
      .clk     (clk_i),
      .clr     (clr),
      .wr_en   (wr_fire && (wr_ptr == BW'(b))),
      .tap     (tap_cnt),
      .wr_data (wr_data_i),
      .data    (bank_data[b])
`ifdef CUTIE_WBUF_ZEROTAP_EN
      ,
      .zero    (bank_zero[b])
`endif
    );
  end

endmodule

// File: tb/tb_weightbuffer_multibank.sv
// Scoreboard bench for weightbuffer_multibank (K=3, N_BANKS=2).
// Honours CUTIE_WBUF_ZEROTAP_EN when the build defines it.
module tb_weightbuffer_multibank;
  import cutie_wbuf_pkg::*;

  localparam int N_I = 512;
  localparam int K   = 3;
  localparam int NB  = 2;
  localparam int KK  = K * K;
  localparam int TW  = N_I * 2;
  localparam int DW  = KK * TW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [TW-1:0] wr_data_i = '0;
  logic          rd_valid_o;
  logic          rd_release_i = 1'b0;
  logic [DW-1:0] rd_data_o;
  logic [0:0]    rd_bank_o;
  logic [1:0]    fill_o;
`ifdef CUTIE_WBUF_ZEROTAP_EN
  logic [KK-1:0] zero_tap_o;
`endif

  weightbuffer_multibank #(
    .N_I     (N_I),
    .K       (K),
    .N_BANKS (NB)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .wr_valid_i   (wr_valid_i),
    .wr_ready_o   (wr_ready_o),
    .wr_data_i    (wr_data_i),
    .rd_valid_o   (rd_valid_o),
    .rd_release_i (rd_release_i),
    .rd_data_o    (rd_data_o),
    .rd_bank_o    (rd_bank_o),
    .fill_o       (fill_o)
`ifdef CUTIE_WBUF_ZEROTAP_EN
    ,
    .zero_tap_o   (zero_tap_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KK-1:0] zf;
  } kern_t;

  kern_t         sb[$];
  logic [DW-1:0] part;
  logic [KK-1:0] part_z;
  int            tap_m;
  int            rdp_m;
  int            n_err;
  int            n_chk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Rotating xor signature keeps data compares on one short line.
  function automatic logic [63:0] sig(input logic [DW-1:0] v);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < DW / 64; i++) begin
      s = {s[62:0], s[63]} ^ v[i*64 +: 64];
    end
    return s;
  endfunction

  function automatic logic [TW-1:0] spec_tap(input int i);
    logic [TW-1:0] d;
    logic [1:0]    t;
    d = {N_I{2'b01}};
    t = 2'(i);
    d[TW-1 -: 2] = t;
    return d;
  endfunction

  function automatic logic [TW-1:0] rnd_tap();
    logic [TW-1:0] d;
    for (int j = 0; j < TW / 32; j++) begin
      d[j*32 +: 32] = $urandom;
    end
    return d;
  endfunction

  // One clock: drive, check against the model, advance the model.
  task automatic cyc(input logic v, input logic [TW-1:0] d,
                     input logic rel, input logic fl, input logic rs);
    logic exp_rdy;
    wr_valid_i   = v;
    wr_data_i    = d;
    rd_release_i = rel;
    flush_i      = fl;
    rst_i        = rs;
    #1;
    exp_rdy = (sb.size() != NB) && !fl && !rs;
    check("wr_ready", 64'(wr_ready_o), 64'(exp_rdy));
    check("rd_valid", 64'(rd_valid_o), 64'(sb.size() != 0));
    check("fill", 64'(fill_o), 64'(sb.size()));
    check("rd_bank", 64'(rd_bank_o), 64'(rdp_m));
    if (sb.size() != 0) begin
      check("rd_data", sig(rd_data_o), sig(sb[0].data));
`ifdef CUTIE_WBUF_ZEROTAP_EN
      check("zero_tap", 64'(zero_tap_o), 64'(sb[0].zf));
`endif
    end
    if (fl || rs) begin
      sb.delete();
      tap_m = 0;
      rdp_m = 0;
    end else begin
      if (rel && sb.size() != 0) begin
        void'(sb.pop_front());
        rdp_m = (rdp_m + 1) % NB;
      end
      if (v && exp_rdy) begin
        part[(KK-1-tap_m)*TW +: TW] = d;
        part_z[KK-1-tap_m]          = (d == '0);
        tap_m++;
        if (tap_m == KK) begin
          sb.push_back('{data: part, zf: part_z});
          tap_m = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [TW-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic post_clear();
    check("clr_fill", 64'(fill_o), 64'd0);
    check("clr_valid", 64'(rd_valid_o), 64'd0);
    check("clr_data", sig(rd_data_o), 64'd0);
`ifdef CUTIE_WBUF_ZEROTAP_EN
    check("clr_zero", 64'(zero_tap_o), 64'd0);
`endif
  endtask

  logic [TW-1:0] held;

  initial begin
    n_err = 0;
    n_chk = 0;
    tap_m = 0;
    rdp_m = 0;
    part   = '0;
    part_z = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(wr_ready_o), 64'd0);
    rst_i = 1'b0;
    #1;
    check("rst_ready_after", 64'(wr_ready_o), 64'd1);
    check("rst_bank", 64'(rd_bank_o), 64'd0);
    post_clear();
    @(negedge clk);

    for (int i = 0; i < KK; i++) beat(spec_tap(i));
    idle();
    for (int i = 0; i < KK; i++) beat(rnd_tap());
    held = rnd_tap();
    beat(held);
    beat(held);
    cyc(1'b1, held, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < KK; i++) beat(i == 0 ? held : rnd_tap());
    idle();

    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < KK - 1; i++) beat(rnd_tap());
    cyc(1'b1, rnd_tap(), 1'b1, 1'b0, 1'b0);
    idle();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) beat(rnd_tap());
    cyc(1'b1, rnd_tap(), 1'b0, 1'b1, 1'b0);
    post_clear();
    for (int i = 0; i < KK; i++) begin
      beat((i % 4 == 0) ? '0 : rnd_tap());
    end
`ifdef CUTIE_WBUF_ZEROTAP_EN
    #1;
    check("zero_pattern", 64'(zero_tap_o), 64'(9'b100010001));
`endif
    idle();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    post_clear();

    for (int i = 0; i < 5; i++) beat(rnd_tap());
    cyc(1'b1, rnd_tap(), 1'b0, 1'b0, 1'b1);
    post_clear();

    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 4) != 0,
          (($urandom % 4) == 0) ? '0 : rnd_tap(),
          ($urandom % 3) == 0,
          ($urandom % 60) == 0,
          ($urandom % 150) == 0);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
